// File: rtl/lc3_mem_access.sv
// LC-3 memory-access stage: runs LD/LDR/LDI/ST/STR/STI against a req/ack data memory,
// sequencing indirect ops as a pointer read followed by the real access.
module lc3_mem_access #(
   parameter int DATA_W   = 16,
   parameter int MAX_WAIT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_valid,
   input  logic [1:0]        mem_op,
   input  logic [DATA_W-1:0] ea_in,
   input  logic [DATA_W-1:0] st_data,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_din,
   input  logic [DATA_W-1:0] dmem_dout,
   input  logic              dmem_ack,
   output logic              mem_busy,
   output logic              mem_done,
   output logic [DATA_W-1:0] memout,
   output logic              mem_err
);

   typedef enum logic [2:0] {IDLE, RD_IND, RD, WR, DONE} state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t            state, next_state;
   logic [DATA_W-1:0] addr_r, data_r;
   logic [1:0]        op_r;
   logic [7:0]        wait_cnt;
   logic              timeout;

   // A request gives up on the cycle it would reach MAX_WAIT unacked; an ack that cycle wins.
   assign timeout   = dmem_req && !dmem_ack && (wait_cnt == WAIT_LAST);
   assign dmem_addr = addr_r;
   assign dmem_din  = data_r;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (mem_valid) begin
               case (mem_op)
                  2'b00:   next_state = RD;
                  2'b01:   next_state = WR;
                  default: next_state = RD_IND;
               endcase
            end
         end
         RD_IND: begin
            if (dmem_ack)     next_state = (op_r == 2'b11) ? WR : RD;
            else if (timeout) next_state = DONE;
         end
         RD, WR: begin
            if (dmem_ack || timeout) next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      mem_busy = 1'b0;
      mem_done = 1'b0;
      case (state)
         RD_IND, RD: begin
            dmem_req = 1'b1;
            mem_busy = 1'b1;
         end
         WR: begin
            dmem_req = 1'b1;
            dmem_we  = 1'b1;
            mem_busy = 1'b1;
         end
         DONE:    mem_done = 1'b1;
         default: ;
      endcase
   end

   // Datapath registers; the pointer from an indirect read overwrites the address in place.
   always_ff @(posedge clk) begin
      if (!rst) begin
         addr_r   <= '0;
         data_r   <= '0;
         op_r     <= 2'b00;
         wait_cnt <= 8'd0;
         memout   <= '0;
         mem_err  <= 1'b0;
      end else begin
         if (state != next_state)      wait_cnt <= 8'd0;
         else if (dmem_req && !dmem_ack) wait_cnt <= wait_cnt + 8'd1;

         if (state == IDLE && mem_valid) begin
            addr_r <= ea_in;
            data_r <= st_data;
            op_r   <= mem_op;
         end

         if (state == RD_IND && dmem_ack) addr_r <= dmem_dout;
         if (state == RD && dmem_ack)     memout <= dmem_dout;
         if (timeout)                     mem_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_lc3_mem_access.sv
// Bench for lc3_mem_access: a behavioural memory answers requests, expected request
// records are queued per scenario and matched against what the DUT issued.
module tb_lc3_mem_access;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [15:0] din;
      logic        acked;
   } req_t;

   logic        clk, rst, mem_valid, dmem_req, dmem_we, dmem_ack;
   logic        mem_busy, mem_done, mem_err;
   logic [1:0]  mem_op;
   logic [15:0] ea_in, st_data, dmem_addr, dmem_din, dmem_dout, memout;

   req_t        expQ[$];
   req_t        obsQ[$];
   logic [15:0] mem [logic [15:0]];
   int          vectors, miscompares;

   int          doneCycle;
   logic [15:0] doneMemout, doneAddr;
   logic        doneErr, postDone, postBusy;
   logic [39:0] busyMask;

   lc3_mem_access #(.DATA_W(16), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_op(mem_op),
      .ea_in(ea_in), .st_data(st_data), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_din(dmem_din), .dmem_dout(dmem_dout),
      .dmem_ack(dmem_ack), .mem_busy(mem_busy), .mem_done(mem_done),
      .memout(memout), .mem_err(mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Presents one op, then plays memory: acks each request after 'waits' unacked cycles.
   task automatic serviceOp(input logic [1:0] op, input logic [15:0] ea, input logic [15:0] sd,
                            input int waits, input bit ackOn);
      int   cyc, reqCnt;
      req_t r;
      obsQ.delete();
      doneCycle = -1;
      busyMask  = '0;
      @(negedge clk);
      mem_valid = 1'b1; mem_op = op; ea_in = ea; st_data = sd;
      @(negedge clk);
      mem_valid = 1'b0;
      mem_op = 2'($urandom); ea_in = 16'($urandom); st_data = 16'($urandom);
      cyc = 1; reqCnt = 0;
      while (cyc < 40 && doneCycle < 0) begin
         dmem_ack  = 1'b0;
         dmem_dout = 16'($urandom);
         if (mem_busy) busyMask[cyc] = 1'b1;
         if (mem_done) begin
            doneCycle  = cyc;
            doneMemout = memout;
            doneAddr   = dmem_addr;
            doneErr    = mem_err;
         end else begin
            if (dmem_req) begin
               r.we = dmem_we; r.addr = dmem_addr; r.din = dmem_din;
               r.acked = ackOn && (reqCnt == waits);
               if (r.acked) begin
                  dmem_ack = 1'b1;
                  if (dmem_we) mem[dmem_addr] = dmem_din;
                  else dmem_dout = mem.exists(dmem_addr) ? mem[dmem_addr] : 16'h0000;
                  reqCnt = 0;
               end else begin
                  reqCnt++;
               end
               obsQ.push_back(r);
            end
            @(negedge clk);
            cyc++;
         end
      end
      dmem_ack = 1'b0;
      @(negedge clk);
      postDone = mem_done;
      postBusy = mem_busy;
   endtask

   task automatic test_reset();
      rst = 1'b0; mem_valid = 1'b0; mem_op = 2'b00; ea_in = '0; st_data = '0;
      dmem_ack = 1'b0; dmem_dout = '0;
      repeat (2) @(negedge clk);
      vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_req got %b required 0", dmem_req); end
      vectors++; if (dmem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_we got %b required 0", dmem_we); end
      vectors++; if (mem_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy got %b required 0", mem_busy); end
      vectors++; if (mem_done !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_done got %b required 0", mem_done); end
      vectors++; if (memout !== 16'h0000) begin miscompares++; $display("[TB] FAIL rst_memout got %h required 0000", memout); end
      vectors++; if (mem_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_err got %b required 0", mem_err); end
      rst = 1'b1;
   endtask

   task automatic test_load();
      req_t e, o;
      mem[16'h3010] = 16'hBEEF;
      expQ.delete();
      expQ.push_back(req_t'{1'b0, 16'h3010, 16'h0000, 1'b1});
      serviceOp(2'b00, 16'h3010, 16'h0000, 0, 1'b1);
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); vectors++;
         if (obsQ.size() == 0) begin miscompares++; $display("[TB] FAIL load_req missing, required addr=%h", e.addr); end
         else begin
            o = obsQ.pop_front();
            if (o !== e) begin miscompares++; $display("[TB] FAIL load_req got we=%b addr=%h din=%h ack=%b required we=%b addr=%h din=%h ack=%b", o.we, o.addr, o.din, o.acked, e.we, e.addr, e.din, e.acked); end
         end
      end
      vectors++; if (obsQ.size() != 0) begin miscompares++; $display("[TB] FAIL load_extra got %0d extra requests required 0", obsQ.size()); end
      vectors++; if (doneCycle != 2) begin miscompares++; $display("[TB] FAIL load_latency got cycle %0d required 2", doneCycle); end
      vectors++; if (doneMemout !== 16'hBEEF) begin miscompares++; $display("[TB] FAIL load_memout got %h required BEEF", doneMemout); end
      vectors++; if (busyMask !== 40'h2) begin miscompares++; $display("[TB] FAIL load_busy got %h required 0000000002", busyMask); end
      vectors++; if (postDone !== 1'b0) begin miscompares++; $display("[TB] FAIL load_done_pulse got %b required 0", postDone); end
   endtask

   task automatic test_store_wait();
      req_t e, o;
      mem[16'h4000] = 16'h0000;
      expQ.delete();
      repeat (3) expQ.push_back(req_t'{1'b1, 16'h4000, 16'h1234, 1'b0});
      expQ.push_back(req_t'{1'b1, 16'h4000, 16'h1234, 1'b1});
      serviceOp(2'b01, 16'h4000, 16'h1234, 3, 1'b1);
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); vectors++;
         if (obsQ.size() == 0) begin miscompares++; $display("[TB] FAIL store_req missing, required addr=%h", e.addr); end
         else begin
            o = obsQ.pop_front();
            if (o !== e) begin miscompares++; $display("[TB] FAIL store_req got we=%b addr=%h din=%h ack=%b required we=%b addr=%h din=%h ack=%b", o.we, o.addr, o.din, o.acked, e.we, e.addr, e.din, e.acked); end
         end
      end
      vectors++; if (obsQ.size() != 0) begin miscompares++; $display("[TB] FAIL store_extra got %0d extra requests required 0", obsQ.size()); end
      vectors++; if (doneCycle != 5) begin miscompares++; $display("[TB] FAIL store_latency got cycle %0d required 5", doneCycle); end
      vectors++; if (mem[16'h4000] !== 16'h1234) begin miscompares++; $display("[TB] FAIL store_mem got %h required 1234", mem[16'h4000]); end
      vectors++; if (doneMemout !== 16'hBEEF) begin miscompares++; $display("[TB] FAIL store_memout got %h required BEEF", doneMemout); end
      vectors++; if (doneErr !== 1'b0) begin miscompares++; $display("[TB] FAIL store_err got %b required 0", doneErr); end
      vectors++; if (busyMask !== 40'h1E) begin miscompares++; $display("[TB] FAIL store_busy got %h required 000000001e", busyMask); end
      vectors++; if (postBusy !== 1'b0) begin miscompares++; $display("[TB] FAIL store_post_busy got %b required 0", postBusy); end
   endtask

   task automatic test_load_ind();
      req_t e, o;
      mem[16'h3020] = 16'h5000;
      mem[16'h5000] = 16'h00AA;
      expQ.delete();
      expQ.push_back(req_t'{1'b0, 16'h3020, 16'h0101, 1'b1});
      expQ.push_back(req_t'{1'b0, 16'h5000, 16'h0101, 1'b1});
      serviceOp(2'b10, 16'h3020, 16'h0101, 0, 1'b1);
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); vectors++;
         if (obsQ.size() == 0) begin miscompares++; $display("[TB] FAIL ldi_req missing, required addr=%h", e.addr); end
         else begin
            o = obsQ.pop_front();
            if (o !== e) begin miscompares++; $display("[TB] FAIL ldi_req got we=%b addr=%h din=%h ack=%b required we=%b addr=%h din=%h ack=%b", o.we, o.addr, o.din, o.acked, e.we, e.addr, e.din, e.acked); end
         end
      end
      vectors++; if (obsQ.size() != 0) begin miscompares++; $display("[TB] FAIL ldi_extra got %0d extra requests required 0", obsQ.size()); end
      vectors++; if (doneCycle != 3) begin miscompares++; $display("[TB] FAIL ldi_latency got cycle %0d required 3", doneCycle); end
      vectors++; if (doneMemout !== 16'h00AA) begin miscompares++; $display("[TB] FAIL ldi_memout got %h required 00AA", doneMemout); end
      vectors++; if (busyMask !== 40'h6) begin miscompares++; $display("[TB] FAIL ldi_busy got %h required 0000000006", busyMask); end
   endtask

   task automatic test_store_ind();
      req_t e, o;
      mem[16'h3021] = 16'h6000;
      mem[16'h6000] = 16'h0000;
      expQ.delete();
      expQ.push_back(req_t'{1'b0, 16'h3021, 16'hFFFF, 1'b1});
      expQ.push_back(req_t'{1'b1, 16'h6000, 16'hFFFF, 1'b1});
      serviceOp(2'b11, 16'h3021, 16'hFFFF, 0, 1'b1);
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); vectors++;
         if (obsQ.size() == 0) begin miscompares++; $display("[TB] FAIL sti_req missing, required addr=%h", e.addr); end
         else begin
            o = obsQ.pop_front();
            if (o !== e) begin miscompares++; $display("[TB] FAIL sti_req got we=%b addr=%h din=%h ack=%b required we=%b addr=%h din=%h ack=%b", o.we, o.addr, o.din, o.acked, e.we, e.addr, e.din, e.acked); end
         end
      end
      vectors++; if (obsQ.size() != 0) begin miscompares++; $display("[TB] FAIL sti_extra got %0d extra requests required 0", obsQ.size()); end
      vectors++; if (doneCycle != 3) begin miscompares++; $display("[TB] FAIL sti_latency got cycle %0d required 3", doneCycle); end
      vectors++; if (mem[16'h6000] !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL sti_mem got %h required FFFF", mem[16'h6000]); end
      vectors++; if (doneMemout !== 16'h00AA) begin miscompares++; $display("[TB] FAIL sti_memout got %h required 00AA", doneMemout); end
   endtask

   task automatic test_timeout();
      req_t e, o;
      mem[16'h3030] = 16'h7777;
      expQ.delete();
      repeat (4) expQ.push_back(req_t'{1'b0, 16'h3030, 16'h0000, 1'b0});
      serviceOp(2'b00, 16'h3030, 16'h0000, 0, 1'b0);
      while (expQ.size() > 0) begin
         e = expQ.pop_front(); vectors++;
         if (obsQ.size() == 0) begin miscompares++; $display("[TB] FAIL tmo_req missing, required addr=%h", e.addr); end
         else begin
            o = obsQ.pop_front();
            if (o !== e) begin miscompares++; $display("[TB] FAIL tmo_req got we=%b addr=%h din=%h ack=%b required we=%b addr=%h din=%h ack=%b", o.we, o.addr, o.din, o.acked, e.we, e.addr, e.din, e.acked); end
         end
      end
      vectors++; if (obsQ.size() != 0) begin miscompares++; $display("[TB] FAIL tmo_extra got %0d extra requests required 0", obsQ.size()); end
      vectors++; if (doneCycle != 5) begin miscompares++; $display("[TB] FAIL tmo_latency got cycle %0d required 5", doneCycle); end
      vectors++; if (doneErr !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_err got %b required 1", doneErr); end
      vectors++; if (doneMemout !== 16'h00AA) begin miscompares++; $display("[TB] FAIL tmo_memout got %h required 00AA", doneMemout); end
      vectors++; if (doneAddr !== 16'h3030) begin miscompares++; $display("[TB] FAIL tmo_addr got %h required 3030", doneAddr); end
      vectors++; if (busyMask !== 40'h1E) begin miscompares++; $display("[TB] FAIL tmo_busy got %h required 000000001e", busyMask); end
      serviceOp(2'b00, 16'h3010, 16'h0000, 0, 1'b1);
      vectors++; if (doneCycle != 2) begin miscompares++; $display("[TB] FAIL tmo_next_latency got cycle %0d required 2", doneCycle); end
      vectors++; if (doneMemout !== 16'hBEEF) begin miscompares++; $display("[TB] FAIL tmo_next_memout got %h required BEEF", doneMemout); end
      vectors++; if (doneErr !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_sticky_err got %b required 1", doneErr); end
   endtask

   task automatic test_reset_mid_op();
      @(negedge clk);
      mem_valid = 1'b1; mem_op = 2'b10; ea_in = 16'h3040; st_data = 16'h0000;
      @(negedge clk);
      mem_valid = 1'b0;
      @(negedge clk);
      vectors++; if (dmem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_req_wait got %b required 1", dmem_req); end
      rst = 1'b0;
      @(negedge clk);
      vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_req got %b required 0", dmem_req); end
      vectors++; if (mem_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_busy got %b required 0", mem_busy); end
      vectors++; if (memout !== 16'h0000) begin miscompares++; $display("[TB] FAIL mid_rst_memout got %h required 0000", memout); end
      vectors++; if (mem_err !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_err got %b required 0", mem_err); end
      rst = 1'b1;
      dmem_ack = 1'b1; dmem_dout = 16'h1234;
      @(negedge clk);
      dmem_ack = 1'b0;
      vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL late_ack_req got %b required 0", dmem_req); end
      vectors++; if (dmem_addr !== 16'h0000) begin miscompares++; $display("[TB] FAIL late_ack_addr got %h required 0000", dmem_addr); end
      vectors++; if (memout !== 16'h0000) begin miscompares++; $display("[TB] FAIL late_ack_memout got %h required 0000", memout); end
      @(negedge clk);
      vectors++; if (mem_done !== 1'b0 || mem_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL late_ack_state got done=%b busy=%b required 0 0", mem_done, mem_busy); end
      serviceOp(2'b00, 16'h3010, 16'h0000, 0, 1'b1);
      vectors++; if (doneCycle != 2 || doneMemout !== 16'hBEEF) begin miscompares++; $display("[TB] FAIL recover_load got cycle %0d memout %h required 2 BEEF", doneCycle, doneMemout); end
      vectors++; if (doneErr !== 1'b0) begin miscompares++; $display("[TB] FAIL recover_err got %b required 0", doneErr); end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_load();
      test_store_wait();
      test_load_ind();
      test_store_ind();
      test_timeout();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
